// File: rtl/branch_resolve_if.sv
`default_nettype none
// ============================================================================
// Module  : branch_resolve_if
// Brief   : EX-stage to EX/MEM bus for the branch resolve stage.
// Revision: 1.0
// ============================================================================
interface branch_resolve_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
);
  logic              valid_in;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              is_branch;
  logic [1:0]        br_type;
  logic              br_annul;
  logic [PC_W-1:0]   br_target;

  logic              ex_valid;
  logic [DATA_W-1:0] ex_result;
  logic              ex_killed;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              slot_err;

  modport master (
    output valid_in, alu_result, alu_zero, is_branch, br_type, br_annul, br_target,
    input  ex_valid, ex_result, ex_killed, redirect_valid, redirect_pc, slot_err
  );

  modport slave (
    input  valid_in, alu_result, alu_zero, is_branch, br_type, br_annul, br_target,
    output ex_valid, ex_result, ex_killed, redirect_valid, redirect_pc, slot_err
  );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_stage.sv
`default_nettype none
// ============================================================================
// Module  : branch_resolve_stage
// Brief   : EX/MEM latch with branch resolution, delay-slot counting/annul and
//           one-cycle fetch redirect.
// Revision: 1.0
// ============================================================================
module branch_resolve_stage #(
  parameter int DATA_W      = 32,
  parameter int PC_W        = 32,
  parameter int DELAY_SLOTS = 1
) (
  input  wire logic       clk,
  input  wire logic       rst,
  branch_resolve_if.slave bus
);

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_SLOT = 1'b1;

  localparam logic [1:0] c_BR_BEQ  = 2'd0;
  localparam logic [1:0] c_BR_BNE  = 2'd1;
  localparam logic [1:0] c_BR_JUMP = 2'd2;

  localparam logic [1:0] c_SLOTS   = DELAY_SLOTS[1:0];

  logic [0:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              taken_q, taken_d;
  logic              annul_q, annul_d;
  logic [PC_W-1:0]   target_q, target_d;

  logic              ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0] ex_result_q, ex_result_d;
  logic              ex_killed_q, ex_killed_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [PC_W-1:0]   redirect_pc_q, redirect_pc_d;
  logic              slot_err_q, slot_err_d;

  logic              w_taken;
  logic              w_kill;

  always_comb begin
    case (bus.br_type)
      c_BR_BEQ:  w_taken = bus.alu_zero;
      c_BR_BNE:  w_taken = ~bus.alu_zero;
      c_BR_JUMP: w_taken = 1'b1;
      default:   w_taken = 1'b0;
    endcase
  end

  assign w_kill = annul_q & ~taken_q;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    taken_d          = taken_q;
    annul_d          = annul_q;
    target_d         = target_q;
    ex_valid_d       = 1'b0;
    ex_result_d      = ex_result_q;
    ex_killed_d      = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    slot_err_d       = 1'b0;

    // While fetch is being redirected, the EX instruction is wrong-path.
    if (!redirect_valid_q && bus.valid_in) begin
      ex_result_d = bus.alu_result;
      if (state_q == c_ST_IDLE) begin
        ex_valid_d = 1'b1;
        if (bus.is_branch) begin
          taken_d  = w_taken;
          annul_d  = bus.br_annul;
          target_d = bus.br_target;
          if (c_SLOTS == 2'd0) begin
            redirect_valid_d = w_taken;
            if (w_taken) begin
              redirect_pc_d = bus.br_target;
            end
          end else begin
            cnt_d   = c_SLOTS;
            state_d = c_ST_SLOT;
          end
        end
      end else begin
        ex_valid_d  = ~w_kill;
        ex_killed_d = w_kill;
        slot_err_d  = bus.is_branch;
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end
        if (cnt_q <= 2'd1) begin
          redirect_valid_d = taken_q;
          if (taken_q) begin
            redirect_pc_d = target_q;
          end
          state_d = c_ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= c_ST_IDLE;
      cnt_q            <= 2'd0;
      taken_q          <= 1'b0;
      annul_q          <= 1'b0;
      target_q         <= '0;
      ex_valid_q       <= 1'b0;
      ex_result_q      <= '0;
      ex_killed_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      slot_err_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      taken_q          <= taken_d;
      annul_q          <= annul_d;
      target_q         <= target_d;
      ex_valid_q       <= ex_valid_d;
      ex_result_q      <= ex_result_d;
      ex_killed_q      <= ex_killed_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      slot_err_q       <= slot_err_d;
    end
  end

  assign bus.ex_valid       = ex_valid_q;
  assign bus.ex_result      = ex_result_q;
  assign bus.ex_killed      = ex_killed_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.slot_err       = slot_err_q;

endmodule
`default_nettype wire
